// File: rtl/pipeline_hazard_ctrl_pkg.sv
// hazard_pkg: shared encodings for the pipeline hazard controller.
//   state_e : FSM state, also exported on the debug 'state' port.
//   sel_e   : PC source select driven on redirect_sel.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_JMP = 2'b01,
    SEL_BR  = 2'b10
  } sel_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the pipe stages and the
// stall/flush/redirect controls back to them.
//   master : pipeline side (drives hazard inputs, receives controls)
//   slave  : hazard controller side
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             memRead_EXE;
  logic [4:0]       regWriteAddress_EXE;
  logic [4:0]       regAddress1_ID;
  logic [4:0]       regAddress2_ID;
  logic             usesRs_ID;
  logic             usesRt_ID;
  logic             jumpTaken_EXE;
  logic             branchTaken_MEM;
  logic             memBusy;

  logic             PCWrite;
  logic [1:0]       redirect_sel;
  logic             IFID_write;
  logic             IFID_flush;
  logic             IDEXE_flush;
  logic             EXEMEM_flush;
  logic             pipe_hold;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       state;

  modport master (
    output memRead_EXE, regWriteAddress_EXE, regAddress1_ID, regAddress2_ID,
           usesRs_ID, usesRt_ID, jumpTaken_EXE, branchTaken_MEM, memBusy,
    input  PCWrite, redirect_sel, IFID_write, IFID_flush, IDEXE_flush,
           EXEMEM_flush, pipe_hold, mem_timeout, stall_cnt, flush_cnt, state
  );

  modport slave (
    input  memRead_EXE, regWriteAddress_EXE, regAddress1_ID, regAddress2_ID,
           usesRs_ID, usesRt_ID, jumpTaken_EXE, branchTaken_MEM, memBusy,
    output PCWrite, redirect_sel, IFID_write, IFID_flush, IDEXE_flush,
           EXEMEM_flush, pipe_hold, mem_timeout, stall_cnt, flush_cnt, state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones.
//   clk_i   : clock, rising edge
//   clr_n_i : synchronous active-low clear (wins over inc_i)
//   inc_i   : count one event this cycle
//   cnt_o   : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_n_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!clr_n_i)                 cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipe.
//   CLK   : clock, rising edge
//   Reset : synchronous active-low reset
//   hz    : slave side of pipeline_hazard_ctrl_if (hazard inputs,
//           PC/stage-register controls, statistics, debug state)
// Controls are combinational from state and inputs; state, wait counter and
// statistics are registered.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic                  CLK,
  input  logic                  Reset,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic pc_write, ifid_write, ifid_flush, idexe_flush, exemem_flush, hold;
  logic redirect, load_use;
  sel_e sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Writes to $0 never create a real dependency.
  assign load_use = hz.memRead_EXE && (hz.regWriteAddress_EXE != 5'd0) &&
                    ((hz.usesRs_ID && hz.regAddress1_ID == hz.regWriteAddress_EXE) ||
                     (hz.usesRt_ID && hz.regAddress2_ID == hz.regWriteAddress_EXE));

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    pc_write     = 1'b0;
    sel          = SEL_SEQ;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idexe_flush  = 1'b0;
    exemem_flush = 1'b0;
    hold         = 1'b0;
    redirect     = 1'b0;
    if (!Reset) begin
      // Drain every stage register to bubbles.
      ifid_flush   = 1'b1;
      idexe_flush  = 1'b1;
      exemem_flush = 1'b1;
      state_d      = RUN;
      wait_d       = '0;
    end else if (state_q == ERROR) begin
      hold = 1'b1;
    end else if (hz.memBusy) begin
      hold = 1'b1;
      if (state_q == MEM_WAIT) begin
        if (wait_q == WAIT_W'(TIMEOUT)) state_d = ERROR;
        else                            wait_d  = wait_q + WAIT_W'(1);
      end else begin
        state_d = MEM_WAIT;
        wait_d  = WAIT_W'(1);
      end
    end else begin
      // RUN, LD_STALL, or MEM_WAIT whose memory just completed: the pipe
      // advances this cycle and any branch/jump waiting in it acts now.
      state_d  = RUN;
      pc_write = 1'b1;
      if (hz.branchTaken_MEM) begin
        // Older branch wins; a jump sitting in EXE is on the wrong path.
        sel          = SEL_BR;
        ifid_flush   = 1'b1;
        idexe_flush  = 1'b1;
        exemem_flush = 1'b1;
        redirect     = 1'b1;
      end else if (hz.jumpTaken_EXE) begin
        sel         = SEL_JMP;
        ifid_flush  = 1'b1;
        idexe_flush = 1'b1;
        redirect    = 1'b1;
      end else if (load_use && state_q != LD_STALL) begin
        // One bubble into EXE; the load then sits in MEM and forwards.
        pc_write    = 1'b0;
        idexe_flush = 1'b1;
        state_d     = LD_STALL;
      end else begin
        ifid_write = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (CLK),
    .clr_n_i (Reset),
    .inc_i   (Reset && !pc_write),
    .cnt_o   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (CLK),
    .clr_n_i (Reset),
    .inc_i   (redirect),
    .cnt_o   (flush_cnt)
  );

  assign hz.PCWrite      = pc_write;
  assign hz.redirect_sel = sel;
  assign hz.IFID_write   = ifid_write;
  assign hz.IFID_flush   = ifid_flush;
  assign hz.IDEXE_flush  = idexe_flush;
  assign hz.EXEMEM_flush = exemem_flush;
  assign hz.pipe_hold    = hold;
  assign hz.mem_timeout  = Reset && (state_q == ERROR);
  assign hz.stall_cnt    = stall_cnt;
  assign hz.flush_cnt    = flush_cnt;
  assign hz.state        = state_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (CNT_W=4, TIMEOUT=8).
// Inputs change on the falling edge; combinational outputs are checked 1ns
// later, registered values are checked at the following falling edge.
module tb_pipeline_hazard_ctrl;
  logic CLK;
  logic Reset;
  int   checks   = 0;
  int   failures = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(4)) hz ();

  pipeline_hazard_ctrl #(.CNT_W(4), .TIMEOUT(8)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .hz    (hz.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] wa, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urs, input logic urt,
                       input logic jmp, input logic br, input logic busy);
    hz.memRead_EXE         = mr;
    hz.regWriteAddress_EXE = wa;
    hz.regAddress1_ID      = rs;
    hz.regAddress2_ID      = rt;
    hz.usesRs_ID           = urs;
    hz.usesRt_ID           = urt;
    hz.jumpTaken_EXE       = jmp;
    hz.branchTaken_MEM     = br;
    hz.memBusy             = busy;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [2:0] flushes();
    return {hz.IFID_flush, hz.IDEXE_flush, hz.EXEMEM_flush};
  endfunction

  initial begin
    Reset = 1'b0;
    idle();

    // Reset: drain outputs, then cleared state/counters.
    @(negedge CLK); #1;
    chk("rst_pcwrite", 16'(hz.PCWrite), 16'h0);
    chk("rst_flushes", 16'(flushes()), 16'h7);
    chk("rst_ifid_wr", 16'(hz.IFID_write), 16'h0);
    chk("rst_hold", 16'(hz.pipe_hold), 16'h0);
    chk("rst_sel", 16'(hz.redirect_sel), 16'h0);
    chk("rst_timeout", 16'(hz.mem_timeout), 16'h0);
    @(negedge CLK);
    chk("rst_state", 16'(hz.state), 16'h0);
    chk("rst_stall_cnt", 16'(hz.stall_cnt), 16'h0);
    chk("rst_flush_cnt", 16'(hz.flush_cnt), 16'h0);
    Reset = 1'b1; #1;
    chk("norm_pcwrite", 16'(hz.PCWrite), 16'h1);
    chk("norm_ifid_wr", 16'(hz.IFID_write), 16'h1);
    chk("norm_flushes", 16'(flushes()), 16'h0);

    // 1: lw $2 in EXE, ID reads rs=$2.
    @(negedge CLK);
    drive(1'b1, 5'd2, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("lu_pcwrite", 16'(hz.PCWrite), 16'h0);
    chk("lu_ifid_wr", 16'(hz.IFID_write), 16'h0);
    chk("lu_flushes", 16'(flushes()), 16'h2);
    @(negedge CLK); #1;
    chk("lu_state", 16'(hz.state), 16'h1);
    chk("lu_suppress_pcw", 16'(hz.PCWrite), 16'h1);
    idle();
    @(negedge CLK);
    chk("lu_back_run", 16'(hz.state), 16'h0);
    chk("lu_stall_cnt", 16'(hz.stall_cnt), 16'h1);

    // rt-side dependency also stalls; usesRt=0 masks it.
    drive(1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("rt_unused_pcw", 16'(hz.PCWrite), 16'h1);
    drive(1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("rt_used_pcw", 16'(hz.PCWrite), 16'h0);
    @(negedge CLK); idle();
    @(negedge CLK);
    chk("rt_stall_cnt", 16'(hz.stall_cnt), 16'h2);

    // 2: load to $0, ID reads $0.
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("r0_pcwrite", 16'(hz.PCWrite), 16'h1);
    @(negedge CLK); idle();
    chk("r0_stall_cnt", 16'(hz.stall_cnt), 16'h2);

    // 3: branch + jump together, then jump alone.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); #1;
    chk("br_sel", 16'(hz.redirect_sel), 16'h2);
    chk("br_flushes", 16'(flushes()), 16'h7);
    chk("br_pcwrite", 16'(hz.PCWrite), 16'h1);
    @(negedge CLK); idle();
    chk("br_flush_cnt", 16'(hz.flush_cnt), 16'h1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
    chk("jmp_sel", 16'(hz.redirect_sel), 16'h1);
    chk("jmp_flushes", 16'(flushes()), 16'h6);
    @(negedge CLK); idle();
    chk("jmp_flush_cnt", 16'(hz.flush_cnt), 16'h2);

    // 4: memBusy for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
      chk("busy3_hold", 16'(hz.pipe_hold), 16'h1);
      chk("busy3_pcwrite", 16'(hz.PCWrite), 16'h0);
      @(negedge CLK);
    end
    idle(); #1;
    chk("busy3_done_pcw", 16'(hz.PCWrite), 16'h1);
    chk("busy3_done_hold", 16'(hz.pipe_hold), 16'h0);
    @(negedge CLK);
    chk("busy3_run", 16'(hz.state), 16'h0);
    chk("busy3_stall_cnt", 16'(hz.stall_cnt), 16'h5);

    // 5: memBusy for 10 cycles -> ERROR after the 9th.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
      if (i == 8) chk("to_wait_9th", 16'(hz.state), 16'h2);
      if (i == 9) chk("to_error_10th", 16'(hz.state), 16'h3);
      @(negedge CLK);
    end
    // A branch must not escape ERROR.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
    chk("err_state", 16'(hz.state), 16'h3);
    chk("err_timeout", 16'(hz.mem_timeout), 16'h1);
    chk("err_pcwrite", 16'(hz.PCWrite), 16'h0);
    chk("err_hold", 16'(hz.pipe_hold), 16'h1);
    @(negedge CLK); idle();
    @(negedge CLK);
    chk("err_sticky", 16'(hz.mem_timeout), 16'h1);
    chk("err_stall_sat", 16'(hz.stall_cnt), 16'hf);
    Reset = 1'b0; #1;
    chk("err_rst_timeout", 16'(hz.mem_timeout), 16'h0);
    chk("err_rst_flushes", 16'(flushes()), 16'h7);
    @(negedge CLK);
    Reset = 1'b1; #1;
    chk("err_cleared_state", 16'(hz.state), 16'h0);
    chk("err_cleared_to", 16'(hz.mem_timeout), 16'h0);
    chk("err_cleared_stall", 16'(hz.stall_cnt), 16'h0);

    // 6: 20 redirects saturate the 4-bit flush counter.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, i[0], ~i[0], 1'b0);
      @(negedge CLK);
    end
    idle();
    chk("sat_flush_cnt", 16'(hz.flush_cnt), 16'hf);
    chk("sat_stall_cnt", 16'(hz.stall_cnt), 16'h0);

    // Reset while in LD_STALL.
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("ldrst_in_stall", 16'(hz.state), 16'h1);
    Reset = 1'b0; #1;
    chk("ldrst_pcwrite", 16'(hz.PCWrite), 16'h0);
    chk("ldrst_flushes", 16'(flushes()), 16'h7);
    @(negedge CLK);
    Reset = 1'b1; idle(); #1;
    chk("ldrst_state", 16'(hz.state), 16'h0);
    chk("ldrst_stall_cnt", 16'(hz.stall_cnt), 16'h0);
    chk("ldrst_flush_cnt", 16'(hz.flush_cnt), 16'h0);
    chk("ldrst_pcwrite_run", 16'(hz.PCWrite), 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
